// File: rtl/regfile_sb_bypass_pkg.sv
// Shared types for the bypassing register file: address type, sweep FSM states
// and the hardwired-zero register index.
package regfile_sb_bypass_pkg;

    localparam int PKG_NREGS = 32;
    localparam int PKG_AW    = $clog2(PKG_NREGS);

    typedef logic [PKG_AW-1:0] reg_addr_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_sb_bypass_scoreboard.sv
// Per-register busy bits: issue sets, write-fire clears, bulk clear for flush/sweep.
// Each read port sees its register as free in the cycle its producer writes back.
module regfile_scoreboard
    import regfile_sb_bypass_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_set,
    input  logic [AW-1:0]     iss_addr,
    input  logic              clr_all,
    input  logic              w_fire,
    input  logic [AW-1:0]     waddr,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD-1:0]    rbusy
);

    logic [NREGS-1:0] busy_q, busy_d;

    // Ordering gives set priority over both the write clear and the bulk clear.
    always_comb begin
        busy_d = busy_q;
        if (clr_all) busy_d = '0;
        if (w_fire) busy_d[waddr] = 1'b0;
        if (iss_set) busy_d[iss_addr] = 1'b1;
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rbusy
        logic [AW-1:0] ra;
        assign ra       = raddr[k*AW +: AW];
        assign rbusy[k] = busy_q[ra] & ~(w_fire && (waddr == ra));
    end

endmodule

// File: rtl/regfile_sb_bypass.sv
// Byte-enabled register file with N bypassing read ports, busy scoreboard and a
// sweep-clear FSM that zeroes one register per cycle while blocking writes.
module regfile_sb_bypass
    import regfile_sb_bypass_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS),
    localparam int NB   = XLEN / 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                wena,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic [NB-1:0]       sel,
    output logic                w_ready,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    input  logic                clr_req,
    output logic                clr_busy
);

    logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
    state_t                     state_q, state_d;
    logic [AW-1:0]              cnt_q, cnt_d;
    logic                       idle;
    logic                       w_fire;
    logic [XLEN-1:0]            wmerged;

    assign idle     = (state_q == IDLE);
    assign w_ready  = idle;
    assign clr_busy = ~idle;
    assign w_fire   = wena & w_ready;

    // Write value after lane merge; shared by the storage update and the bypass.
    always_comb begin
        wmerged = regs_q[waddr];
        for (int b = 0; b < NB; b++)
            if (sel[b]) wmerged[b*8 +: 8] = wdata[b*8 +: 8];
    end

    always_comb begin
        regs_d = regs_q;
        if (state_q == SWEEP)
            regs_d[cnt_q] = '0;
        else if (w_fire && (waddr != AW'(REG_ZERO)))
            regs_d[waddr] = wmerged;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(NREGS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            regs_q  <= regs_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        assign ra = raddr[k*AW +: AW];
        always_comb begin
            rd = regs_q[ra];
            if (w_fire && (waddr == ra)) rd = wmerged;
            if (ra == AW'(REG_ZERO)) rd = '0;
        end
        assign rdata[k*XLEN +: XLEN] = rd;
    end

    // Sweep start wipes the scoreboard and suppresses that cycle's issue.
    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .iss_set  (idle & iss_valid & ~clr_req & (iss_addr != AW'(REG_ZERO))),
        .iss_addr (iss_addr),
        .clr_all  (idle & (flush | clr_req)),
        .w_fire   (w_fire),
        .waddr    (waddr),
        .raddr    (raddr),
        .rbusy    (rbusy)
    );

endmodule

// File: tb/tb_regfile_sb_bypass.sv
// Directed bench for regfile_sb_bypass: expectations are queued as stimulus is
// driven and popped against the combinational outputs at the falling edge.
module tb_regfile_sb_bypass;
    import regfile_sb_bypass_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [9:0]   raddr;
    logic [127:0] rdata;
    logic [1:0]   rbusy;
    logic         wena;
    reg_addr_t    waddr;
    logic [63:0]  wdata;
    logic [7:0]   sel;
    logic         w_ready;
    logic         iss_valid;
    reg_addr_t    iss_addr;
    logic         flush;
    logic         clr_req;
    logic         clr_busy;

    regfile_sb_bypass dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wena(wena), .waddr(waddr), .wdata(wdata), .sel(sel), .w_ready(w_ready),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush),
        .clr_req(clr_req), .clr_busy(clr_busy)
    );

    always #5 clk = ~clk;

    localparam int K_RD = 0, K_BUSY = 1, K_WRDY = 2, K_CBSY = 3;

    typedef struct {
        string       tag;
        int          kind;
        int          port;
        logic [63:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [63:0] val(int i);
        return 64'hC0DE_0000_0000_0000 + 64'(i);
    endfunction

    function automatic logic [63:0] obs(int kind, int port);
        case (kind)
            K_RD:    return rdata[port*64 +: 64];
            K_BUSY:  return {63'b0, rbusy[port]};
            K_WRDY:  return {63'b0, w_ready};
            default: return {63'b0, clr_busy};
        endcase
    endfunction

    task automatic push(input string tag, input int kind, input int port, input logic [63:0] exp);
        exp_t e;
        e.tag = tag; e.kind = kind; e.port = port; e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic chk();
        exp_t        e;
        logic [63:0] o;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs(e.kind, e.port);
            checks++;
            assert (o === e.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        wena = 1'b0; waddr = '0; wdata = '0; sel = '0;
        iss_valid = 1'b0; iss_addr = '0; flush = 1'b0; clr_req = 1'b0;
    endtask

    task automatic set_rd(input int k, input int a);
        raddr[k*5 +: 5] = 5'(a);
    endtask

    task automatic wr(input int a, input logic [63:0] d, input logic [7:0] s);
        wena = 1'b1; waddr = 5'(a); wdata = d; sel = s;
    endtask

    task automatic fill_all();
        for (int i = 1; i < 32; i++) begin
            idle_in();
            wr(i, val(i), 8'hFF);
            cyc();
        end
        idle_in();
    endtask

    task automatic read_all_zero(input string tag);
        for (int i = 0; i < 32; i += 2) begin
            idle_in();
            set_rd(0, i); set_rd(1, i + 1);
            push(tag, K_RD, 0, 64'h0);
            push(tag, K_RD, 1, 64'h0);
            push({tag, "_busy"}, K_BUSY, 0, 64'h0);
            push({tag, "_busy"}, K_BUSY, 1, 64'h0);
            chk();
            cyc();
        end
    endtask

    initial begin
        rst = 1'b1; raddr = '0;
        idle_in();
        cyc(); cyc();
        rst = 1'b0;

        // Reset state
        set_rd(0, 5); set_rd(1, 31);
        push("rst_wready", K_WRDY, 0, 64'h1);
        push("rst_clrbusy", K_CBSY, 0, 64'h0);
        push("rst_rd5", K_RD, 0, 64'h0);
        push("rst_rd31", K_RD, 1, 64'h0);
        push("rst_busy", K_BUSY, 0, 64'h0);
        chk(); cyc();

        // Byte-merge write
        wr(5, 64'h1122334455667788, 8'hFF);
        push("bm_full_bypass", K_RD, 0, 64'h1122334455667788);
        chk(); cyc();
        wr(5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        push("bm_part_bypass", K_RD, 0, 64'h11223344AAAAAAAA);
        chk(); cyc();
        idle_in(); set_rd(1, 5);
        push("bm_stored_p0", K_RD, 0, 64'h11223344AAAAAAAA);
        push("bm_stored_p1", K_RD, 1, 64'h11223344AAAAAAAA);
        chk(); cyc();

        // Register 0 stays zero, including in the write cycle
        wr(0, '1, 8'hFF); set_rd(0, 0); set_rd(1, 0);
        push("r0_wcyc_p0", K_RD, 0, 64'h0);
        push("r0_wcyc_p1", K_RD, 1, 64'h0);
        chk(); cyc();
        idle_in();
        push("r0_after_p0", K_RD, 0, 64'h0);
        push("r0_after_p1", K_RD, 1, 64'h0);
        chk(); cyc();

        // Bypass on both ports to the same register
        wr(3, 64'h0, 8'hFF);
        cyc();
        wr(3, 64'h000000000000FFFF, 8'h03); set_rd(0, 3); set_rd(1, 3);
        push("byp_p0", K_RD, 0, 64'h000000000000FFFF);
        push("byp_p1", K_RD, 1, 64'h000000000000FFFF);
        chk(); cyc();
        idle_in();
        push("byp_stored", K_RD, 0, 64'h000000000000FFFF);
        chk(); cyc();

        // Scoreboard: set, set-vs-clear, clear with bypass
        iss_valid = 1'b1; iss_addr = 5'd7; set_rd(0, 7);
        push("sb_iss_samecyc", K_BUSY, 0, 64'h0);
        chk(); cyc();
        idle_in();
        push("sb_iss_next", K_BUSY, 0, 64'h1);
        chk(); cyc();
        iss_valid = 1'b1; iss_addr = 5'd7; wr(7, 64'h77, 8'hFF);
        push("sb_setclr_wcyc", K_BUSY, 0, 64'h0);
        chk(); cyc();
        idle_in();
        push("sb_set_wins", K_BUSY, 0, 64'h1);
        chk(); cyc();
        wr(7, 64'h78, 8'hFF);
        push("sb_wr_clr_wcyc", K_BUSY, 0, 64'h0);
        chk(); cyc();
        idle_in();
        push("sb_wr_clr_after", K_BUSY, 0, 64'h0);
        chk(); cyc();

        // Write with sel=0 clears busy but leaves data alone
        iss_valid = 1'b1; iss_addr = 5'd5; cyc();
        idle_in(); wr(5, '1, 8'h00); set_rd(0, 5);
        push("sel0_data_wcyc", K_RD, 0, 64'h11223344AAAAAAAA);
        push("sel0_busy_wcyc", K_BUSY, 0, 64'h0);
        chk(); cyc();
        idle_in();
        push("sel0_data_after", K_RD, 0, 64'h11223344AAAAAAAA);
        push("sel0_busy_after", K_BUSY, 0, 64'h0);
        chk(); cyc();

        // Flush with concurrent issue
        iss_valid = 1'b1; iss_addr = 5'd7; cyc();
        iss_valid = 1'b1; iss_addr = 5'd12; cyc();
        idle_in(); set_rd(0, 12);
        push("fl_pre_r12", K_BUSY, 0, 64'h1);
        chk();
        cyc();
        flush = 1'b1; iss_valid = 1'b1; iss_addr = 5'd9; cyc();
        idle_in(); set_rd(0, 7); set_rd(1, 9);
        push("fl_r7", K_BUSY, 0, 64'h0);
        push("fl_r9", K_BUSY, 1, 64'h1);
        chk(); cyc();
        set_rd(0, 12);
        push("fl_r12", K_BUSY, 0, 64'h0);
        chk(); cyc();

        // Sweep
        fill_all();
        iss_valid = 1'b1; iss_addr = 5'd20; cyc();
        idle_in();
        clr_req = 1'b1; wr(2, 64'h2222, 8'hFF); set_rd(0, 2); set_rd(1, 20);
        push("sw_start_wr", K_RD, 0, 64'h2222);
        push("sw_start_busy20", K_BUSY, 1, 64'h1);
        chk(); cyc();
        for (int j = 0; j < 32; j++) begin
            idle_in();
            if (j == 1) begin
                set_rd(0, 4); set_rd(1, 20);
                push("sw_rd4_unswept", K_RD, 0, val(4));
                push("sw_rd20_unswept", K_RD, 1, val(20));
                push("sw_busy_cleared", K_BUSY, 1, 64'h0);
            end
            if (j == 2) begin
                iss_valid = 1'b1; iss_addr = 5'd21; flush = 1'b1; clr_req = 1'b1;
            end
            if (j == 10) begin
                wr(4, 64'hDEAD, 8'hFF); set_rd(0, 4);
                push("sw_wr_nobypass", K_RD, 0, 64'h0);
            end
            push("sw_clr_busy", K_CBSY, 0, 64'h1);
            push("sw_w_ready", K_WRDY, 0, 64'h0);
            chk(); cyc();
        end
        idle_in();
        push("sw_end_clr_busy", K_CBSY, 0, 64'h0);
        push("sw_end_w_ready", K_WRDY, 0, 64'h1);
        chk();
        read_all_zero("sw_after");

        // Reset in the middle of a sweep
        fill_all();
        iss_valid = 1'b1; iss_addr = 5'd20; cyc();
        idle_in(); clr_req = 1'b1; cyc();
        for (int j = 0; j <= 10; j++) begin
            idle_in();
            if (j == 10) rst = 1'b1;
            push("rs_clr_busy", K_CBSY, 0, 64'h1);
            chk(); cyc();
        end
        rst = 1'b0; idle_in();
        push("rs_clr_busy_after", K_CBSY, 0, 64'h0);
        push("rs_w_ready_after", K_WRDY, 0, 64'h1);
        chk();
        read_all_zero("rs_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
